// File: rtl/tape_mem.sv
// Shared tape memory serving one load and one store per cycle; loads return after two cycles.
// Define TAPE_MEM_CLEAR_EN to zero the whole tape after reset before ready rises.
module tape_mem #(
   parameter int ADDR_W = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ld_en,
   input  logic [15:0] ld_addr,
   output logic [15:0] ld_data,
   output logic        ld_valid,
   input  logic        st_en,
   input  logic [15:0] st_addr,
   input  logic [15:0] st_data,
   output logic        ready
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {CLEAR, RUN} state_t;

`ifdef TAPE_MEM_CLEAR_EN
   localparam state_t RESET_STATE = CLEAR;
`else
   localparam state_t RESET_STATE = RUN;
`endif

   state_t            state_q, state_d;
   logic              ready_q, ready_d;
   logic [15:0]       mem_q [DEPTH];

   logic [ADDR_W-1:0] ld_idx, st_idx, wr_idx;
   logic              wr_en;
   logic [15:0]       wr_dat;
   logic              st_go, ld_go, st_hit;
   logic [15:0]       rd_dat;

   logic              s1_vld_q, s1_vld_d;
   logic [15:0]       s1_dat_q, s1_dat_d;
   logic              ld_vld_q, ld_vld_d;
   logic [15:0]       ld_dat_q, ld_dat_d;

   // Pointer bits above the tape index are ignored so the tape wraps.
   logic              unused_hi;
   assign unused_hi = ^{ld_addr[15:ADDR_W], st_addr[15:ADDR_W]};

   assign ld_idx = ld_addr[ADDR_W-1:0];
   assign st_idx = st_addr[ADDR_W-1:0];
   assign st_go  = ready_q && st_en;
   assign ld_go  = ready_q && ld_en;

`ifdef TAPE_MEM_CLEAR_EN
   logic [ADDR_W-1:0] sweep_q, sweep_d;
`endif

   always_comb begin
      state_d = state_q;
      wr_en   = 1'b0;
      wr_idx  = st_idx;
      wr_dat  = st_data;
`ifdef TAPE_MEM_CLEAR_EN
      sweep_d = sweep_q;
`endif
      case (state_q)
         CLEAR: begin
`ifdef TAPE_MEM_CLEAR_EN
            wr_en   = 1'b1;
            wr_idx  = sweep_q;
            wr_dat  = 16'h0000;
            sweep_d = sweep_q + 1'b1;
            if (&sweep_q) state_d = RUN;
`else
            state_d = RUN;
`endif
         end
         RUN: begin
            wr_en = st_go;
         end
         default: state_d = RESET_STATE;
      endcase
      // ready follows the state one edge later, so it is low in the first cycle after release.
      ready_d = (state_d == RUN);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RESET_STATE;
         ready_q <= 1'b0;
`ifdef TAPE_MEM_CLEAR_EN
         sweep_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         ready_q <= ready_d;
`ifdef TAPE_MEM_CLEAR_EN
         sweep_q <= sweep_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_idx] <= wr_dat;
   end

   // A same-cycle store to the loaded cell is forwarded so the load sees it.
   assign st_hit = st_go && (st_idx == ld_idx);
   assign rd_dat = st_hit ? st_data : mem_q[ld_idx];

   always_comb begin
      s1_vld_d = ld_go;
      s1_dat_d = ld_go ? rd_dat : s1_dat_q;
      ld_vld_d = s1_vld_q;
      ld_dat_d = s1_vld_q ? s1_dat_q : ld_dat_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q <= 1'b0;
         s1_dat_q <= 16'h0000;
         ld_vld_q <= 1'b0;
         ld_dat_q <= 16'h0000;
      end else begin
         s1_vld_q <= s1_vld_d;
         s1_dat_q <= s1_dat_d;
         ld_vld_q <= ld_vld_d;
         ld_dat_q <= ld_dat_d;
      end
   end

   assign ld_data  = ld_dat_q;
   assign ld_valid = ld_vld_q;
   assign ready    = ready_q;

endmodule
